// File: rtl/exp3_pkg.sv
// Shared widths, types and ROM contents for the sequence-memory game datapath.
package exp3_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 4;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Sequence the player has to reproduce, address 0 first
    localparam word_t [0:15] ROM_INIT = '{
        4'h1, 4'h2, 4'h4, 4'h8,
        4'h4, 4'h2, 4'h1, 4'h1,
        4'h2, 4'h2, 4'h4, 4'h4,
        4'h8, 4'h8, 4'h1, 4'h4
    };

endpackage

// File: rtl/exp3_fluxo_dados_rom_16x4.sv
// Combinational 16x4 ROM holding the game sequence; zero-latency read.
module rom_16x4
    import exp3_pkg::*;
(
    input  addr_t i_addr,
    output word_t o_data
);

    assign o_data = ROM_INIT[i_addr];

endmodule

// File: rtl/exp3_fluxo_dados.sv
// Datapath for the sequence-memory game: address counter, ROM, switch register, comparator.
// Debug buses are live only when FLUXO_DADOS_DB_EN is defined; otherwise they read zero.
module exp3_fluxo_dados
    import exp3_pkg::*;
(
    input  logic              clock,
    input  logic              zeraC,
    input  logic              zeraR,
    input  logic              contaC,
    input  logic              registraR,
    input  logic [DATA_W-1:0] chaves,
    output logic              chavesIgualMemoria,
    output logic              fimC,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [DATA_W-1:0] db_chaves,
    output logic [DATA_W-1:0] db_memoria
);

    addr_t r_cnt;
    word_t r_chaves;
    word_t w_memoria;

    always_ff @(posedge clock or posedge zeraC) begin
        if (zeraC) begin
            r_cnt <= '0;
        end else if (contaC) begin
            r_cnt <= r_cnt + addr_t'(1);
        end
    end

    always_ff @(posedge clock or posedge zeraR) begin
        if (zeraR) begin
            r_chaves <= '0;
        end else if (registraR) begin
            r_chaves <= chaves;
        end
    end

    rom_16x4 u_rom (
        .i_addr (r_cnt),
        .o_data (w_memoria)
    );

    assign chavesIgualMemoria = (r_chaves == w_memoria);
    assign fimC               = &r_cnt;

`ifdef FLUXO_DADOS_DB_EN
    assign db_contagem = r_cnt;
    assign db_chaves   = r_chaves;
    assign db_memoria  = w_memoria;
`else
    assign db_contagem = '0;
    assign db_chaves   = '0;
    assign db_memoria  = '0;
`endif

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// Directed self-checking bench for exp3_fluxo_dados; debug-bus checks follow FLUXO_DADOS_DB_EN.
module tb_exp3_fluxo_dados;

    logic       clock;
    logic       zeraC;
    logic       zeraR;
    logic       contaC;
    logic       registraR;
    logic [3:0] chaves;
    logic       chavesIgualMemoria;
    logic       fimC;
    logic [3:0] db_contagem;
    logic [3:0] db_chaves;
    logic [3:0] db_memoria;

    int checks = 0;
    int errors = 0;

    exp3_fluxo_dados dut (
        .clock              (clock),
        .zeraC              (zeraC),
        .zeraR              (zeraR),
        .contaC             (contaC),
        .registraR          (registraR),
        .chaves             (chaves),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimC               (fimC),
        .db_contagem        (db_contagem),
        .db_chaves          (db_chaves),
        .db_memoria         (db_memoria)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Debug buses mirror internal state only in the debug build
    task automatic chk_db(input string tag, input logic [3:0] obs, input logic [3:0] internal);
`ifdef FLUXO_DADOS_DB_EN
        chk(tag, obs, internal);
`else
        chk(tag, obs, 4'h0);
`endif
    endtask

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        zeraC = 1'b0; zeraR = 1'b0; contaC = 1'b0; registraR = 1'b0; chaves = 4'h0;
        #3;

        // 1: clear both
        zeraC = 1'b1; zeraR = 1'b1;
        tick();
        zeraC = 1'b0; zeraR = 1'b0;
        chk_db("rst_cnt", db_contagem, 4'h0);
        chk_db("rst_reg", db_chaves, 4'h0);
        chk_db("rst_mem", db_memoria, 4'h1);
        chk("rst_igual", {3'b0, chavesIgualMemoria}, 4'h0);
        chk("rst_fim", {3'b0, fimC}, 4'h0);

        // 2: switches change without load, then load
        chaves = 4'h1;
        tick();
        chk_db("noload_reg", db_chaves, 4'h0);
        chk("noload_igual", {3'b0, chavesIgualMemoria}, 4'h0);
        registraR = 1'b1;
        tick();
        registraR = 1'b0;
        chk_db("load1_reg", db_chaves, 4'h1);
        chk("load1_igual", {3'b0, chavesIgualMemoria}, 4'h1);

        // 3: advance to address 1
        contaC = 1'b1;
        tick();
        contaC = 1'b0;
        chk_db("a1_cnt", db_contagem, 4'h1);
        chk_db("a1_mem", db_memoria, 4'h2);
        chk("a1_igual", {3'b0, chavesIgualMemoria}, 4'h0);
        chaves = 4'h2; registraR = 1'b1;
        tick();
        registraR = 1'b0;
        chk("a1_load_igual", {3'b0, chavesIgualMemoria}, 4'h1);

        // 4: address 2, load a mismatching value
        contaC = 1'b1;
        tick();
        contaC = 1'b0;
        chk_db("a2_cnt", db_contagem, 4'h2);
        chk_db("a2_mem", db_memoria, 4'h4);
        chaves = 4'h8; registraR = 1'b1;
        tick();
        registraR = 1'b0;
        chk_db("a2_reg", db_chaves, 4'h8);
        chk("a2_igual", {3'b0, chavesIgualMemoria}, 4'h0);

        // 5: run to the end and wrap; ROM[12] is 8 and matches the register
        contaC = 1'b1;
        repeat (10) tick();
        chk_db("a12_cnt", db_contagem, 4'hC);
        chk("a12_igual", {3'b0, chavesIgualMemoria}, 4'h1);
        chk("a12_fim", {3'b0, fimC}, 4'h0);
        repeat (3) tick();
        contaC = 1'b0;
        chk_db("a15_cnt", db_contagem, 4'hF);
        chk("a15_fim", {3'b0, fimC}, 4'h1);
        chk_db("a15_mem", db_memoria, 4'h4);
        chk("a15_igual", {3'b0, chavesIgualMemoria}, 4'h0);
        contaC = 1'b1;
        tick();
        contaC = 1'b0;
        chk_db("wrap_cnt", db_contagem, 4'h0);
        chk("wrap_fim", {3'b0, fimC}, 4'h0);
        chk_db("wrap_mem", db_memoria, 4'h1);

        // 6: async register clear between edges
        #2;
        zeraR = 1'b1;
        #1;
        chk_db("zr_reg", db_chaves, 4'h0);
        zeraR = 1'b0;
        tick();
        chk_db("zr_hold", db_chaves, 4'h0);

        // Reach address 3 (ROM 8) and load a match
        contaC = 1'b1;
        repeat (3) tick();
        contaC = 1'b0;
        chaves = 4'h8; registraR = 1'b1;
        tick();
        registraR = 1'b0;
        chk("a3_igual", {3'b0, chavesIgualMemoria}, 4'h1);

        // Async counter clear overriding a live increment enable
        contaC = 1'b1;
        #2;
        zeraC = 1'b1;
        #1;
        chk_db("zc_cnt", db_contagem, 4'h0);
        chk("zc_igual", {3'b0, chavesIgualMemoria}, 4'h0);
        repeat (2) tick();
        chk_db("zc_hold_cnt", db_contagem, 4'h0);
        chk_db("zc_hold_mem", db_memoria, 4'h1);
        zeraC = 1'b0;
        tick();
        chk_db("post_zc_cnt", db_contagem, 4'h1);
        chk_db("post_zc_mem", db_memoria, 4'h2);

        // Simultaneous count and load
        chaves = 4'h4; registraR = 1'b1;
        tick();
        contaC = 1'b0; registraR = 1'b0;
        chk_db("both_cnt", db_contagem, 4'h2);
        chk_db("both_reg", db_chaves, 4'h4);
        chk("both_igual", {3'b0, chavesIgualMemoria}, 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
